// File: rtl/debug_cmd_dispatch.sv
// System-clock command dispatcher for the JTAG debug slave: synchronises TCK-side toggle events,
// queues {IR, DR} commands in a FIFO and hands them out with one-hot action pulses.
// Optional DEBUG_CMD_DISPATCH_TIMESTAMP_EN adds a free-running timestamp stored with each entry.
module debug_cmd_dispatch #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
`ifdef DEBUG_CMD_DISPATCH_TIMESTAMP_EN
  , parameter int TS_W      = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uir_tgl,
  input  logic                    e1dr_tgl,
  input  logic [IR_W-1:0]         ir_in,
  input  logic [DR_W-1:0]         sr,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [IR_W-1:0]         cmd_ir,
  output logic [DR_W-1:0]         cmd_data,
`ifdef DEBUG_CMD_DISPATCH_TIMESTAMP_EN
  output logic [TS_W-1:0]         cmd_ts,
`endif
  output logic [(2**IR_W)-1:0]    action,
  output logic [IR_W-1:0]         ir_cur,
  output logic [$clog2(DEPTH):0]  cmd_count,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACT_W = 2**IR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_e1dr_sync;
  logic                   r_uir_hist;
  logic                   r_e1dr_hist;

  logic [IR_W-1:0]  r_mem_ir   [DEPTH];
  logic [DR_W-1:0]  r_mem_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [IR_W-1:0]  r_ir_cur;
  logic [ACT_W-1:0] r_action;
  logic             r_overflow;

  logic             w_uir_evt;
  logic             w_e1dr_evt;
  logic [IR_W-1:0]  w_push_ir;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [ACT_W-1:0] w_action_next;

  // Event fires while the new level sits in the last stage but not yet in the history flop.
  assign w_uir_evt  = r_uir_sync[SYNC_STAGES-1]  ^ r_uir_hist;
  assign w_e1dr_evt = r_e1dr_sync[SYNC_STAGES-1] ^ r_e1dr_hist;

  assign w_push_ir = w_uir_evt ? ir_in : r_ir_cur;
  assign cmd_valid = (r_count != '0);
  assign w_pop     = cmd_valid && cmd_ready;
  assign w_push    = w_e1dr_evt && ((r_count != FULL_CNT) || w_pop);
  assign w_drop    = w_e1dr_evt && !w_push;

  assign cmd_ir    = r_mem_ir[r_rd_ptr];
  assign cmd_data  = r_mem_data[r_rd_ptr];
  assign action    = r_action;
  assign ir_cur    = r_ir_cur;
  assign cmd_count = r_count;
  assign overflow  = r_overflow;

  genvar gi;
  generate
    for (gi = 0; gi < ACT_W; gi++) begin : g_action
      assign w_action_next[gi] = w_pop && (cmd_ir == IR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_uir_sync  <= '0;
      r_e1dr_sync <= '0;
      r_uir_hist  <= 1'b0;
      r_e1dr_hist <= 1'b0;
    end else begin
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], uir_tgl};
      r_e1dr_sync <= {r_e1dr_sync[SYNC_STAGES-2:0], e1dr_tgl};
      r_uir_hist  <= r_uir_sync[SYNC_STAGES-1];
      r_e1dr_hist <= r_e1dr_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir_cur   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_action   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_uir_evt) begin
        r_ir_cur <= ir_in;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_action <= w_action_next;
      // A drop in the same cycle wins over a clear so no overflow is ever lost.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is cleared on reset so the head outputs are never X while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ir[i]   <= '0;
        r_mem_data[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_ir[r_wr_ptr]   <= w_push_ir;
      r_mem_data[r_wr_ptr] <= sr;
    end
  end

`ifdef DEBUG_CMD_DISPATCH_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_mem_ts [DEPTH];

  assign cmd_ts = r_mem_ts[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ts[i] <= '0;
      end
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      if (w_push) begin
        r_mem_ts[r_wr_ptr] <= r_ts_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/debug_cmd_dispatch.md
Name: debug_cmd_dispatch

Overview:
- System-clock-side command dispatcher for the Nios II JTAG debug slave.
- Receives update-IR and exit1-DR events from the JTAG (TCK) side as toggle levels, plus quasi-static IR and shift-register buses.
- Synchronises the events into clk and queues {IR, DR} commands in a parametrised FIFO.
- Hands commands to the CPU debug logic over a valid/ready handshake, with one-hot per-instruction action pulses.
- Generalises the fixed 2-bit IR, 38-bit DR, unbuffered sysclk decoder to any IR/DR width, FIFO depth and synchroniser length.

Parameters:
- IR_W, 2, instruction register width; action vector width is 2**IR_W.
- DR_W, 38, data (shift) register width.
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- SYNC_STAGES, 2, synchroniser flops per toggle input; at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- uir_tgl  in  1  toggles once per JTAG update-IR; asynchronous to clk.
- e1dr_tgl  in  1  toggles once per JTAG exit1-DR; asynchronous to clk.
- ir_in  in  IR_W  JTAG instruction; stable at least SYNC_STAGES+2 clk cycles around each uir_tgl edge.
- sr  in  DR_W  JTAG shift register; stable at least SYNC_STAGES+2 clk cycles around each e1dr_tgl edge.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer accepts the head entry.
- cmd_ir  out  IR_W  head entry instruction.
- cmd_data  out  DR_W  head entry data.
- action  out  2**IR_W  registered one-hot pulse of the popped instruction.
- ir_cur  out  IR_W  last latched instruction.
- cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag: a command was dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset: synchroniser and history flops, ir_cur, FIFO pointers, cmd_count, action and overflow all go to 0; cmd_valid=0. FIFO contents are don't-care. A reset mid-operation discards all queued commands. Toggle history resets to 0, so an input held at 1 through reset produces one event after release.
- Synchronisers: each toggle passes through SYNC_STAGES flops and then one history flop.
  - event = last stage XOR history.
  - The event is active in the cycle the new level reaches the last stage, i.e. SYNC_STAGES edges after the first sampling edge.
  - One event per toggle edge; no events are merged.
- uir event: ir_cur <= ir_in at that edge.
- e1dr event: push {ir, sr}, where ir is ir_in if a uir event occurs in the same cycle, else ir_cur (IR update takes precedence).
- Push acceptance: accepted iff cmd_count<DEPTH, or a pop occurs in the same cycle.
  - When full with no pop, the push is dropped, contents are unchanged, and overflow<=1.
- Pop: occurs when cmd_valid && cmd_ready.
  - Head advances; cmd_ir/cmd_data show the next entry the following cycle.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop: cmd_count unchanged. When empty, the pushed entry appears the next cycle; there is no bypass.
- cmd_count: +1 on push only, -1 on pop only. cmd_valid = (cmd_count!=0).
- cmd_ir/cmd_data when cmd_valid=0: don't-care, but must not be X after reset (read any entry; the memory may reset to 0).
- action: next cycle after a pop, action[cmd_ir] is 1 for exactly one cycle; otherwise all zero. Back-to-back pops give back-to-back pulses.
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Latency: e1dr_tgl edge to cmd_valid=1 is SYNC_STAGES+1 or SYNC_STAGES+2 clk edges, depending on sampling phase.

Optional Feature:
- Macro: DEBUG_CMD_DISPATCH_TIMESTAMP_EN.
- With the macro:
  - Adds parameter TS_W (default 16) and output port cmd_ts [TS_W-1:0].
  - A free-running counter counts from 0 after reset and wraps at 2**TS_W.
  - The counter value in the push cycle is stored with each entry; cmd_ts shows the head entry's value.
- Without the macro: no counter, no storage and no cmd_ts port. All other behaviour is identical.

Test Plan:
- Reset with SYNC_STAGES=2: toggle uir_tgl with ir_in=2'b01, then toggle e1dr_tgl with sr=38'h2A_DEAD_BEEF -> ir_cur=1. cmd_valid rises 3–4 edges after the e1dr edge, with cmd_ir=1 and cmd_data=38'h2A_DEAD_BEEF. Pop -> action=4'b0010 for exactly one cycle.
- cmd_ready=0, DEPTH=4, five e1dr toggles with sr=1..5 -> cmd_count=4, overflow=1. Pops return 1,2,3,4 in order; entry 5 is lost.
- FIFO full and cmd_ready=1 held while a sixth event arrives -> push accepted, cmd_count stays 4, overflow stays 0.
- uir and e1dr toggled together with ir_in=3, previous ir_cur=0 -> the queued cmd_ir is 3.
- overflow=1; assert ovf_clr in the same cycle as a new dropped push -> overflow remains 1. ovf_clr alone in the next cycle -> overflow=0.
- Reset asserted with 3 entries queued -> next cycle cmd_count=0, cmd_valid=0, action=0. With the timestamp macro defined, a push 10 cycles after reset release gives cmd_ts=10 (±1 per the defined sampling edge).
